// File: rtl/uart_rx_ovs.sv
// 16x-oversampled UART receiver with 3-sample majority vote, optional parity,
// framing/break detection and a first-word-fall-through frame FIFO.
module uart_rx_ovs #(
    parameter int Fclk   = 12_000_000,
    parameter int Bauds  = 115200,
    parameter int Wdata  = 8,
    parameter int Wstop  = 1,
    parameter int Parity = 0,
    parameter int Depth  = 4
) (
    input  logic                     CLK,
    input  logic                     NRST,
    input  logic                     RXD,
    output logic [Wdata-1:0]         DOUT,
    output logic                     PERR,
    output logic                     FERR,
    output logic                     VALID,
    input  logic                     READY,
    output logic                     BREAK,
    output logic                     OVR,
    output logic [$clog2(Depth):0]   COUNT
);

    localparam int NDIV = Fclk / (Bauds * 16);
    localparam int DIVW = (NDIV > 1) ? $clog2(NDIV) : 1;
    localparam int AW   = $clog2(Depth);
    localparam int BCW  = $clog2(Wdata);
    localparam int EW   = Wdata + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
    } state_t;

    state_t           r_state;
    logic             r_sync1, r_sync2;
    logic [DIVW-1:0]  r_div;
    logic [3:0]       r_sub;
    logic [1:0]       r_smp;
    logic [BCW-1:0]   r_bitcnt;
    logic             r_stopcnt;
    logic [Wdata-1:0] r_shift;
    logic             r_par;
    logic             r_ferr;
    logic             r_stop0;
    logic             r_done;
    logic [EW-1:0]    r_ent;
    logic             r_break;

    logic [EW-1:0]    r_mem [Depth];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_count;
    logic             r_ovr;

    logic w_rxs, w_tick, w_dec, w_wrap, w_maj;
    logic w_stop0, w_brk, w_ferr_fin, w_perr, w_last_stop, w_last_bit;
    logic w_valid, w_full, w_pop, w_push;
    logic [EW-1:0] w_head;

    assign w_rxs  = r_sync2;
    assign w_tick = (r_div == DIVW'(NDIV - 1));
    assign w_dec  = w_tick && (r_sub == 4'd9);
    assign w_wrap = w_tick && (r_sub == 4'd15);
    // r_smp holds the s=7 and s=8 samples; the s=9 sample is the live rxs.
    assign w_maj  = (r_smp[0] & r_smp[1]) | (r_smp[0] & w_rxs) | (r_smp[1] & w_rxs);

    assign w_last_bit  = (r_bitcnt == BCW'(Wdata - 1));
    assign w_last_stop = (r_stopcnt == 1'(Wstop - 1));
    assign w_stop0     = (r_stopcnt == 1'b0) ? w_maj : r_stop0;
    assign w_ferr_fin  = r_ferr | ~w_maj;
    assign w_perr      = (Parity == 0) ? 1'b0 : ((^{r_shift, r_par}) ^ (Parity == 1));
    assign w_brk       = (r_shift == '0) && ((Parity == 0) || !r_par) && !w_stop0;

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RXD;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_sub     <= '0;
            r_smp     <= '0;
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_ferr    <= 1'b0;
            r_stop0   <= 1'b0;
            r_done    <= 1'b0;
            r_ent     <= '0;
            r_break   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_break <= 1'b0;
            r_div   <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick)
                r_sub <= r_sub + 1'b1;
            if (w_tick && r_sub == 4'd7)
                r_smp[0] <= w_rxs;
            if (w_tick && r_sub == 4'd8)
                r_smp[1] <= w_rxs;
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state   <= S_START;
                        r_div     <= '0;
                        r_sub     <= '0;
                        r_bitcnt  <= '0;
                        r_stopcnt <= 1'b0;
                        r_ferr    <= 1'b0;
                        r_par     <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_dec && w_maj)
                        r_state <= S_IDLE;
                    else if (w_wrap)
                        r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_dec)
                        r_shift <= {w_maj, r_shift[Wdata-1:1]};
                    if (w_wrap) begin
                        if (w_last_bit)
                            r_state <= (Parity != 0) ? S_PARITY : S_STOP;
                        else
                            r_bitcnt <= r_bitcnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (w_dec)
                        r_par <= w_maj;
                    if (w_wrap)
                        r_state <= S_STOP;
                end
                S_STOP: begin
                    if (w_dec) begin
                        if (r_stopcnt == 1'b0)
                            r_stop0 <= w_maj;
                        r_ferr <= w_ferr_fin;
                        // Leave at mid-bit so a back-to-back start edge is not missed.
                        if (w_last_stop) begin
                            if (w_brk) begin
                                r_break <= 1'b1;
                                r_state <= S_BRKWAIT;
                            end else begin
                                r_done  <= 1'b1;
                                r_ent   <= {w_ferr_fin, w_perr, r_shift};
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    if (w_wrap)
                        r_stopcnt <= 1'b1;
                end
                S_BRKWAIT: begin
                    if (w_rxs)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == (AW+1)'(Depth));
    assign w_pop   = w_valid && READY;
    assign w_push  = r_done && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd];

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= r_done && w_full && !w_pop;
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wr] <= r_ent;
    end

    assign VALID = w_valid;
    assign DOUT  = w_valid ? w_head[Wdata-1:0] : '0;
    assign PERR  = w_valid ? w_head[Wdata]     : 1'b0;
    assign FERR  = w_valid ? w_head[Wdata+1]   : 1'b0;
    assign BREAK = r_break;
    assign OVR   = r_ovr;
    assign COUNT = r_count;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Bench for uart_rx_ovs: one no-parity and one even-parity receiver, directed
// and random frames checked against a frame-level reference model.
module tb_uart_rx_ovs;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic rxd_a = 1'b1, rxd_b = 1'b1, rdy_a = 1'b1, rdy_b = 1'b1;
    logic [7:0] dout_a, dout_b;
    logic perr_a, perr_b, ferr_a, ferr_b, valid_a, valid_b;
    logic brk_a, brk_b, ovr_a, ovr_b;
    logic [2:0] cnt_a, cnt_b;

    uart_rx_ovs #(.Fclk(1600), .Bauds(100), .Wdata(8), .Wstop(1), .Parity(0), .Depth(4)) u_a (
        .CLK(clk), .NRST(nrst), .RXD(rxd_a), .DOUT(dout_a), .PERR(perr_a), .FERR(ferr_a),
        .VALID(valid_a), .READY(rdy_a), .BREAK(brk_a), .OVR(ovr_a), .COUNT(cnt_a));

    uart_rx_ovs #(.Fclk(1600), .Bauds(100), .Wdata(8), .Wstop(1), .Parity(2), .Depth(4)) u_b (
        .CLK(clk), .NRST(nrst), .RXD(rxd_b), .DOUT(dout_b), .PERR(perr_b), .FERR(ferr_b),
        .VALID(valid_b), .READY(rdy_b), .BREAK(brk_b), .OVR(ovr_b), .COUNT(cnt_b));

    int checks = 0;
    int errors = 0;

    logic [9:0] obs_a [0:511];
    logic [9:0] obs_b [0:511];
    int n_a = 0, n_b = 0, vh_a = 0;
    int nbrk_a = 0, nbrk_b = 0, novr_a = 0, novr_b = 0;

    // Popped entries and pulse counts, sampled away from the active edge.
    always @(negedge clk) begin
        if (valid_a) vh_a <= vh_a + 1;
        if (valid_a && rdy_a) begin obs_a[n_a] <= {ferr_a, perr_a, dout_a}; n_a <= n_a + 1; end
        if (valid_b && rdy_b) begin obs_b[n_b] <= {ferr_b, perr_b, dout_b}; n_b <= n_b + 1; end
        if (brk_a) nbrk_a <= nbrk_a + 1;
        if (brk_b) nbrk_b <= nbrk_b + 1;
        if (ovr_a) novr_a <= novr_a + 1;
        if (ovr_b) novr_b <= novr_b + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drv(input int w, input logic v);
        if (w == 0) rxd_a = v; else rxd_b = v;
    endtask

    task automatic send_bit(input int w, input logic v, input bit glitch);
        for (int c = 0; c < 16; c++) begin
            drv(w, (glitch && c == 9) ? ~v : v);
            tick(1);
        end
    endtask

    task automatic send_frame(input int w, input logic [7:0] d, input logic pb,
                              input logic stp, input bit noisy);
        send_bit(w, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(w, d[i], noisy);
        if (w == 1) send_bit(w, pb, 1'b0);
        send_bit(w, stp, 1'b0);
        drv(w, 1'b1);
        tick(32);
    endtask

    // Expected entry {FERR, PERR, DOUT}; dut 1 uses even parity over data+parity bit.
    function automatic logic [9:0] model(input int w, input logic [7:0] d,
                                         input logic pb, input logic stp);
        logic pe;
        pe = (w == 1) ? (($countones({d, pb}) % 2) != 0) : 1'b0;
        return {~stp, pe, d};
    endfunction

    function automatic bit is_break(input int w, input logic [7:0] d,
                                    input logic pb, input logic stp);
        return (d == 8'h00) && (w == 0 || pb == 1'b0) && (stp == 1'b0);
    endfunction

    task automatic rx_check(input int w, input logic [7:0] d, input logic pb,
                            input logic stp, input bit noisy, input string tag);
        int n0, b0, n1, b1;
        logic [9:0] got;
        n0 = (w == 0) ? n_a : n_b;
        b0 = (w == 0) ? nbrk_a : nbrk_b;
        send_frame(w, d, pb, stp, noisy);
        n1 = (w == 0) ? n_a : n_b;
        b1 = (w == 0) ? nbrk_a : nbrk_b;
        if (is_break(w, d, pb, stp)) begin
            chk({tag, "_brk"}, b1 - b0, 1);
            chk({tag, "_nopush"}, n1 - n0, 0);
        end else begin
            got = (w == 0) ? obs_a[n0] : obs_b[n0];
            chk({tag, "_npop"}, n1 - n0, 1);
            chk({tag, "_entry"}, {22'd0, got}, {22'd0, model(w, d, pb, stp)});
            chk({tag, "_nobrk"}, b1 - b0, 0);
        end
    endtask

    initial begin
        int n0, v0, o0, b0;
        logic [7:0] d;
        logic pb, stp;
        bit nz;
        int w;

        tick(4);
        chk("rst_valid_a", valid_a, 0);
        chk("rst_count_a", cnt_a, 0);
        chk("rst_dout_a", {perr_a, ferr_a, dout_a}, 0);
        chk("rst_pulses_a", {brk_a, ovr_a}, 0);
        chk("rst_valid_b", valid_b, 0);
        chk("rst_count_b", cnt_b, 0);
        nrst = 1'b1;
        tick(5);

        v0 = vh_a;
        rx_check(0, 8'hA5, 1'b0, 1'b1, 1'b0, "t1_a5");
        chk("t1_valid_1cyc", vh_a - v0, 1);
        chk("t1_count0", cnt_a, 0);

        rx_check(1, 8'h07, 1'b1, 1'b1, 1'b0, "t2_par_ok");
        rx_check(1, 8'h07, 1'b0, 1'b1, 1'b0, "t2_par_bad");
        chk("t2_perr_set", obs_b[n_b-1][8], 1);

        n0 = n_a;
        drv(0, 1'b0); tick(5); drv(0, 1'b1); tick(40);
        chk("t3_glitch_nopush", n_a - n0, 0);
        chk("t3_glitch_count", cnt_a, 0);
        rx_check(0, 8'h3C, 1'b0, 1'b1, 1'b1, "t3_noise");

        rdy_a = 1'b0;
        o0 = novr_a;
        for (int k = 1; k <= 4; k++) send_frame(0, 8'(k), 1'b0, 1'b1, 1'b0);
        chk("t4_no_ovr_yet", novr_a - o0, 0);
        send_frame(0, 8'h05, 1'b0, 1'b1, 1'b0);
        chk("t4_count_full", cnt_a, 4);
        chk("t4_ovr_once", novr_a - o0, 1);
        n0 = n_a;
        rdy_a = 1'b1;
        tick(10);
        chk("t4_npops", n_a - n0, 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t4_pop%0d", k), {22'd0, obs_a[n0+k]},
                {22'd0, model(0, 8'(k + 1), 1'b0, 1'b1)});
        chk("t4_count_empty", cnt_a, 0);

        b0 = nbrk_a; n0 = n_a;
        drv(0, 1'b0); tick(480); drv(0, 1'b1); tick(40);
        chk("t5_break_once", nbrk_a - b0, 1);
        chk("t5_break_nopush", n_a - n0, 0);
        rx_check(0, 8'h55, 1'b0, 1'b1, 1'b0, "t5_after_brk");
        rx_check(1, 8'h00, 1'b0, 1'b0, 1'b0, "t5_break_par");

        rx_check(0, 8'h81, 1'b0, 1'b0, 1'b0, "t6_ferr");
        rdy_a = 1'b0;
        send_frame(0, 8'h12, 1'b0, 1'b1, 1'b0);
        chk("t6_pending", cnt_a, 1);
        send_bit(0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1, 1'b0);
        nrst = 1'b0; drv(0, 1'b1); tick(3);
        chk("t6_rst_valid", valid_a, 0);
        chk("t6_rst_count", cnt_a, 0);
        nrst = 1'b1; tick(20);
        rdy_a = 1'b1;
        rx_check(0, 8'h34, 1'b0, 1'b1, 1'b0, "t6_after_rst");

        for (int i = 0; i < 24; i++) begin
            w   = i % 2;
            d   = 8'($urandom);
            pb  = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            stp = ($urandom_range(0, 3) != 0);
            nz  = 1'($urandom_range(0, 1));
            tick($urandom_range(0, 20));
            rx_check(w, d, pb, stp, nz, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
